purse_spawn_ctrl: RTL and testbench

- Game-economy sequencer between the player input decoder and the battlefield spawner.
- Accumulates money on a periodic tick and saturates it at the purse maximum for the current level.
- Executes purse upgrades and arbitrates per-type army deploy requests round-robin, subject to cost and per-type cooldown.
- Offers one granted spawn at a time to the battlefield over a valid/ready handshake.

---
 rtl/purse_spawn_ctrl.sv | 176 +++++++++++++++++
 tb/tb_purse_spawn_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/purse_spawn_ctrl.sv
// rtl/purse_spawn_ctrl.sv - money purse, upgrades and round-robin army spawn sequencer
module purse_spawn_ctrl #(
    parameter logic [23:0] TICK_DIV = 24'd5000000,
    parameter logic [14:0] INC_BASE = 15'd10,
    parameter logic [14:0] INC_STEP = 15'd5,
    parameter logic [7:0]  CD_TICKS = 8'd20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  deploy_req,
    input  logic        upgrade_req,
    input  logic        spawn_ready,
    output logic        spawn_valid,
    output logic [2:0]  spawn_type,
    output logic [14:0] money,
    output logic [2:0]  level,
    output logic [7:0]  cd_busy,
    output logic [7:0]  deploy_afford,
    output logic        upgrade_ok
);
    typedef enum logic {S_IDLE, S_OFFER} state_t;

    function automatic logic [14:0] cost_of(input logic [2:0] t);
        case (t)
            3'd0:    return 15'd75;
            3'd1:    return 15'd150;
            3'd2:    return 15'd240;
            3'd3:    return 15'd350;
            3'd4:    return 15'd750;
            3'd5:    return 15'd1500;
            3'd6:    return 15'd2000;
            default: return 15'd2400;
        endcase
    endfunction

    function automatic logic [14:0] need_of(input logic [2:0] l);
        case (l)
            3'd0:    return 15'd100;
            3'd1:    return 15'd200;
            3'd2:    return 15'd400;
            3'd3:    return 15'd800;
            3'd4:    return 15'd1400;
            3'd5:    return 15'd3000;
            3'd6:    return 15'd5000;
            default: return 15'd0;
        endcase
    endfunction

    function automatic logic [14:0] max_of(input logic [2:0] l);
        case (l)
            3'd0:    return 15'd150;
            3'd1:    return 15'd300;
            3'd2:    return 15'd500;
            3'd3:    return 15'd1000;
            3'd4:    return 15'd2000;
            3'd5:    return 15'd4000;
            3'd6:    return 15'd6000;
            default: return 15'd9999;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic        spawn_valid_q, spawn_valid_d;
    logic [2:0]  spawn_type_q, spawn_type_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [14:0] money_q, money_d;
    logic [2:0]  level_q, level_d;
    logic [7:0]  pending_q, pending_d;
    logic [23:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]  cd_q [8];
    logic [7:0]  cd_d [8];

    logic        tick, upg_exec, accept, grant;
    logic [2:0]  grant_type, idx;
    logic [7:0]  afford, cand;
    logic [15:0] credit, debit, sum, cap;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            cd_busy[i] = (cd_q[i] != 8'd0);
            afford[i]  = (money_q >= cost_of(3'(i))) && (cd_q[i] == 8'd0);
        end
    end

    assign deploy_afford = afford;
    assign upgrade_ok    = (level_q != 3'd7) && (money_q >= need_of(level_q)) && (state_q == S_IDLE);
    assign upg_exec      = upgrade_req && upgrade_ok;
    assign accept        = (state_q == S_OFFER) && spawn_ready;
    assign tick          = en && (tick_cnt_q == TICK_DIV - 24'd1);
    assign cand          = pending_q & afford;

    // Round-robin search starts just after the last accepted type; k=8 wraps to ptr itself.
    always_comb begin
        grant      = 1'b0;
        grant_type = 3'd0;
        idx        = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!grant && cand[idx]) begin
                grant      = 1'b1;
                grant_type = idx;
            end
        end
    end

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (en) tick_cnt_d = tick ? 24'd0 : tick_cnt_q + 24'd1;

        level_d = level_q + {2'b00, upg_exec};
        credit  = tick ? ({1'b0, INC_BASE} + 16'(level_q) * {1'b0, INC_STEP}) : 16'd0;
        debit   = accept   ? {1'b0, cost_of(spawn_type_q)} :
                  upg_exec ? {1'b0, need_of(level_q)}      : 16'd0;
        sum     = {1'b0, money_q} - debit + credit;
        cap     = {1'b0, max_of(level_d)};
        money_d = (sum > cap) ? cap[14:0] : sum[14:0];

        pending_d = pending_q | (deploy_req & afford);
        if (state_q == S_IDLE) pending_d = pending_d & afford;
        if (accept) pending_d[spawn_type_q] = 1'b0;

        for (int i = 0; i < 8; i++) begin
            cd_d[i] = cd_q[i];
            if (tick && cd_q[i] != 8'd0) cd_d[i] = cd_q[i] - 8'd1;
            if (accept && spawn_type_q == 3'(i)) cd_d[i] = CD_TICKS;
        end

        state_d       = state_q;
        spawn_valid_d = spawn_valid_q;
        spawn_type_d  = spawn_type_q;
        ptr_d         = ptr_q;
        case (state_q)
            S_IDLE: if (en && grant) begin
                state_d       = S_OFFER;
                spawn_valid_d = 1'b1;
                spawn_type_d  = grant_type;
            end
            S_OFFER: if (spawn_ready) begin
                state_d       = S_IDLE;
                spawn_valid_d = 1'b0;
                ptr_d         = spawn_type_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            spawn_valid_q <= 1'b0;
            spawn_type_q  <= 3'd0;
            ptr_q         <= 3'd7;
            money_q       <= 15'd0;
            level_q       <= 3'd0;
            pending_q     <= 8'd0;
            tick_cnt_q    <= 24'd0;
            for (int i = 0; i < 8; i++) cd_q[i] <= 8'd0;
        end else begin
            state_q       <= state_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_type_q  <= spawn_type_d;
            ptr_q         <= ptr_d;
            money_q       <= money_d;
            level_q       <= level_d;
            pending_q     <= pending_d;
            tick_cnt_q    <= tick_cnt_d;
            for (int i = 0; i < 8; i++) cd_q[i] <= cd_d[i];
        end
    end

    assign spawn_valid = spawn_valid_q;
    assign spawn_type  = spawn_type_q;
    assign money       = money_q;
    assign level       = level_q;
endmodule

// File: tb/tb_purse_spawn_ctrl.sv
// tb/tb_purse_spawn_ctrl.sv - scenario bench for purse_spawn_ctrl
module tb_purse_spawn_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, en, upgrade_req, spawn_ready;
    logic [7:0]  deploy_req;
    logic        spawn_valid, upgrade_ok;
    logic [2:0]  spawn_type, level;
    logic [14:0] money;
    logic [7:0]  cd_busy, deploy_afford;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [2:0] exp_q[$];
    int max_tbl[8] = '{150, 300, 500, 1000, 2000, 4000, 6000, 9999};

    always #5 clk = ~clk;

    purse_spawn_ctrl #(
        .TICK_DIV(24'd4), .INC_BASE(15'd10), .INC_STEP(15'd5), .CD_TICKS(8'd3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .deploy_req(deploy_req),
        .upgrade_req(upgrade_req), .spawn_ready(spawn_ready),
        .spawn_valid(spawn_valid), .spawn_type(spawn_type), .money(money),
        .level(level), .cd_busy(cd_busy), .deploy_afford(deploy_afford),
        .upgrade_ok(upgrade_ok)
    );

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(output bit ok);
        for (int i = 0; i < 40 && !spawn_valid; i++) step();
        ok = spawn_valid;
    endtask

    task automatic wait_money(input logic [14:0] target, output bit ok);
        for (int i = 0; i < 400 && money != target; i++) step();
        ok = (money == target);
    endtask

    task automatic accept(input bit on_tick, output logic [2:0] got, output logic [14:0] m_before);
        while ((((cyc + 1) % 4) == 0) != on_tick) step();
        got = spawn_type;
        m_before = money;
        spawn_ready = 1'b1;
        step();
        spawn_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; deploy_req = 8'd0; upgrade_req = 1'b0; spawn_ready = 1'b0;
        step(); step();
        n_checks++; if (money !== 15'd0) $display("FAIL reset_money got=%0d exp=0", money); else n_pass++;
        n_checks++; if (level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", level); else n_pass++;
        n_checks++; if (spawn_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", spawn_valid); else n_pass++;
        n_checks++; if (cd_busy !== 8'd0) $display("FAIL reset_cd got=%h exp=00", cd_busy); else n_pass++;
        n_checks++; if (deploy_afford !== 8'd0) $display("FAIL reset_afford got=%h exp=00", deploy_afford); else n_pass++;
    endtask

    task automatic test_accumulate();
        int e;
        rst_n = 1'b1; en = 1'b1; cyc = 0;
        step(); step(); step();
        n_checks++; if (money !== 15'd0) $display("FAIL acc_pre_tick got=%0d exp=0", money); else n_pass++;
        step();
        n_checks++; if (money !== 15'd10) $display("FAIL acc_first_tick got=%0d exp=10", money); else n_pass++;
        for (int t = 2; t <= 18; t++) begin
            repeat (4) step();
            e = (10 * t > 150) ? 150 : 10 * t;
            n_checks++; if (money !== 15'(e)) $display("FAIL acc_tick%0d got=%0d exp=%0d", t, money, e); else n_pass++;
        end
        n_checks++; if (deploy_afford !== 8'h03) $display("FAIL acc_afford got=%h exp=03", deploy_afford); else n_pass++;
        n_checks++; if (upgrade_ok !== 1'b1) $display("FAIL acc_upgrade_ok got=%0b exp=1", upgrade_ok); else n_pass++;
    endtask

    task automatic test_spawn_hold();
        bit ok;
        int ticks;
        logic [2:0] got, want;
        logic [14:0] mb;
        exp_q.push_back(3'd0);
        deploy_req = 8'h01; step(); deploy_req = 8'h00;
        n_checks++; if (spawn_valid !== 1'b0) $display("FAIL hold_latency got=%0b exp=0", spawn_valid); else n_pass++;
        step();
        n_checks++; if (spawn_valid !== 1'b1) $display("FAIL hold_valid_rise got=%0b exp=1", spawn_valid); else n_pass++;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (spawn_valid !== 1'b1 || spawn_type !== 3'd0) ok = 1'b0;
        end
        n_checks++; if (!ok) $display("FAIL hold_stable valid=%0b type=%0d exp=1/0", spawn_valid, spawn_type); else n_pass++;
        accept(1'b0, got, mb);
        want = exp_q.pop_front();
        n_checks++; if (got !== want) $display("FAIL hold_type got=%0d exp=%0d", got, want); else n_pass++;
        n_checks++; if (money !== 15'd75) $display("FAIL hold_money got=%0d exp=75", money); else n_pass++;
        n_checks++; if (cd_busy[0] !== 1'b1) $display("FAIL hold_cd_busy got=%0b exp=1", cd_busy[0]); else n_pass++;
        n_checks++; if (deploy_afford !== 8'h00) $display("FAIL hold_afford_cd got=%h exp=00", deploy_afford); else n_pass++;
        n_checks++; if (spawn_valid !== 1'b0) $display("FAIL hold_valid_fall got=%0b exp=0", spawn_valid); else n_pass++;
        ticks = 0;
        deploy_req = 8'h01; step(); deploy_req = 8'h00;
        if (cyc % 4 == 0) ticks++;
        for (int i = 0; i < 30 && cd_busy[0]; i++) begin
            step();
            if (cyc % 4 == 0) ticks++;
        end
        n_checks++; if (ticks !== 3 || cd_busy[0] !== 1'b0) $display("FAIL cd_ticks got=%0d busy=%0b exp=3/0", ticks, cd_busy[0]); else n_pass++;
        step(); step();
        n_checks++; if (spawn_valid !== 1'b0) $display("FAIL cd_req_dropped got=%0b exp=0", spawn_valid); else n_pass++;
    endtask

    task automatic test_accept_on_tick();
        bit ok;
        logic [2:0] got, want;
        logic [14:0] mb;
        wait_money(15'd150, ok);
        n_checks++; if (!ok) $display("FAIL tick_refill got=%0d exp=150", money); else n_pass++;
        exp_q.push_back(3'd0);
        deploy_req = 8'h01; step(); deploy_req = 8'h00;
        wait_valid(ok);
        n_checks++; if (!ok) $display("FAIL tick_offer got=%0b exp=1", spawn_valid); else n_pass++;
        accept(1'b1, got, mb);
        want = exp_q.pop_front();
        n_checks++; if (got !== want) $display("FAIL tick_type got=%0d exp=%0d", got, want); else n_pass++;
        n_checks++; if (money !== 15'd85) $display("FAIL tick_money got=%0d exp=85", money); else n_pass++;
    endtask

    task automatic test_upgrade();
        bit ok;
        logic [14:0] mb;
        wait_money(15'd150, ok);
        n_checks++; if (!ok) $display("FAIL upg_refill got=%0d exp=150", money); else n_pass++;
        while (((cyc + 1) % 4) == 0) step();
        n_checks++; if (upgrade_ok !== 1'b1) $display("FAIL upg_ok got=%0b exp=1", upgrade_ok); else n_pass++;
        upgrade_req = 1'b1; step(); upgrade_req = 1'b0;
        n_checks++; if (level !== 3'd1) $display("FAIL upg_level got=%0d exp=1", level); else n_pass++;
        n_checks++; if (money !== 15'd50) $display("FAIL upg_money got=%0d exp=50", money); else n_pass++;
        for (int i = 0; i < 100 && money < 15'd90; i++) step();
        while (((cyc + 1) % 4) == 0) step();
        mb = money;
        n_checks++; if (upgrade_ok !== 1'b0) $display("FAIL upg_poor_ok got=%0b exp=0", upgrade_ok); else n_pass++;
        upgrade_req = 1'b1; step(); upgrade_req = 1'b0;
        n_checks++; if (level !== 3'd1 || money !== mb) $display("FAIL upg_ignored level=%0d money=%0d exp=1/%0d", level, money, mb); else n_pass++;
    endtask

    task automatic test_round_robin();
        bit ok, over;
        logic [2:0] got, want;
        logic [14:0] mb;
        over = 1'b0;
        for (int i = 0; i < 20000 && !(level == 3'd7 && money == 15'd9999); i++) begin
            if (int'(money) > max_tbl[level]) over = 1'b1;
            upgrade_req = upgrade_ok;
            step();
            upgrade_req = 1'b0;
        end
        n_checks++; if (level !== 3'd7 || money !== 15'd9999) $display("FAIL rr_climb level=%0d money=%0d exp=7/9999", level, money); else n_pass++;
        n_checks++; if (over) $display("FAIL rr_saturation got=over exp=within_max"); else n_pass++;
        n_checks++; if (upgrade_ok !== 1'b0) $display("FAIL rr_lvl7_ok got=%0b exp=0", upgrade_ok); else n_pass++;
        n_checks++; if (deploy_afford !== 8'hFF) $display("FAIL rr_afford got=%h exp=ff", deploy_afford); else n_pass++;
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd5);
        deploy_req = 8'h24; step(); deploy_req = 8'h00;
        wait_valid(ok);
        n_checks++; if (!ok) $display("FAIL rr_offer1 got=%0b exp=1", spawn_valid); else n_pass++;
        accept(1'b0, got, mb);
        want = exp_q.pop_front();
        n_checks++; if (got !== want) $display("FAIL rr_first_type got=%0d exp=%0d", got, want); else n_pass++;
        n_checks++; if (money !== 15'd9759) $display("FAIL rr_first_money got=%0d exp=9759", money); else n_pass++;
        wait_valid(ok);
        n_checks++; if (!ok) $display("FAIL rr_offer2 got=%0b exp=1", spawn_valid); else n_pass++;
        accept(1'b0, got, mb);
        want = exp_q.pop_front();
        n_checks++; if (got !== want) $display("FAIL rr_second_type got=%0d exp=%0d", got, want); else n_pass++;
        n_checks++; if (money !== mb - 15'd1500) $display("FAIL rr_second_money got=%0d exp=%0d", money, mb - 15'd1500); else n_pass++;
        n_checks++; if (cd_busy[5] !== 1'b1) $display("FAIL rr_cd5 got=%0b exp=1", cd_busy[5]); else n_pass++;
    endtask

    task automatic test_reset_mid_offer();
        bit ok;
        deploy_req = 8'h01; step(); deploy_req = 8'h00;
        wait_valid(ok);
        n_checks++; if (!ok) $display("FAIL rst_offer got=%0b exp=1", spawn_valid); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (spawn_valid !== 1'b0 || money !== 15'd0 || level !== 3'd0)
            $display("FAIL rst_async valid=%0b money=%0d level=%0d exp=0/0/0", spawn_valid, money, level); else n_pass++;
        spawn_ready = 1'b1;
        step(); step();
        rst_n = 1'b1; cyc = 0;
        step(); step(); step();
        n_checks++; if (money !== 15'd0 || spawn_valid !== 1'b0) $display("FAIL rst_no_debit money=%0d valid=%0b exp=0/0", money, spawn_valid); else n_pass++;
        spawn_ready = 1'b0;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL sb_drained got=%0d exp=0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_spawn_hold();
        test_accept_on_tick();
        test_upgrade();
        test_round_robin();
        test_reset_mid_offer();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
